hps_ext_master: RTL

//  Initiator side of the 36-bit EXT_BUS word protocol.

---
 rtl/hps_ext_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hps_ext_master.sv
// hps_ext_master - initiator side of the 36-bit EXT_BUS word protocol.
//
// A transaction is one command word followed by 0..31 data words.  Each word
// is one io_strobe pulse preceded by io_enable (SETUP cycles before the first
// strobe) and followed by GAP strobe-low cycles.  The responder answer is
// sampled on the edge that ends the first strobe-low cycle.
//
// Optional feature macro: HPS_EXTM_ABORT_EN
//   defined   : a missing dout_en after the command word skips all data words
//   undefined : all data words are issued, err is only reported
//
// Handshake: wr_data/wr_valid is a valid/ready pair. The bench/producer holds
// wr_data stable while wr_valid=1; a word is consumed in the cycle wr_ready=1,
// which is the strobe cycle of that write word.
//
// Ports
//   clk_sys, reset       clock, synchronous active-high reset
//   start/cmd/len/wr     transaction request, sampled only in IDLE
//   wr_data/wr_valid     write word source, wr_ready marks consumption
//   rd_data/rd_valid     read word, rd_valid is a 1-cycle pulse
//   status/err           command-word response (io_dout / ~dout_en)
//   busy/done            transaction in progress / 1-cycle end pulse
//   dbg_state            current FSM state for observation
//   EXT_BUS              [34]=io_enable [33]=io_strobe [31:16]=io_din driven,
//                        [32]=dout_en [15:0]=io_dout sampled, [35] untouched
module hps_ext_master #(
   parameter int SETUP = 1,
   parameter int GAP   = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] cmd,
   input  logic [4:0]  len,
   input  logic        wr,
   input  logic [15:0] wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic [15:0] status,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [2:0]  dbg_state,
   inout  wire  [35:0] EXT_BUS
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_SAMPLE, S_WAITW, S_DISABLE
   } state_t;

   localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;        // cycles spent in SETUP or SAMPLE
   logic [4:0]  rem_q, rem_d;        // data words not yet strobed
   logic        word0_q, word0_d;    // current word is the command word
   logic [15:0] cmd_q, cmd_d;
   logic        wr_q, wr_d;
   logic [15:0] status_q, status_d;
   logic        err_q, err_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;

   logic        io_enable, io_strobe;
   logic [15:0] io_din;
   logic [15:0] io_dout;
   logic        dout_en;
   logic        abort;
   logic        unused_bus;

   assign io_dout    = EXT_BUS[15:0];
   assign dout_en    = EXT_BUS[32];
   assign unused_bus = EXT_BUS[35];

   assign EXT_BUS[34]    = io_enable;
   assign EXT_BUS[33]    = io_strobe;
   assign EXT_BUS[31:16] = io_din;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      word0_d    = word0_q;
      cmd_d      = cmd_q;
      wr_d       = wr_q;
      status_d   = status_q;
      err_d      = err_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      io_enable  = 1'b0;
      io_strobe  = 1'b0;
      io_din     = 16'h0000;
      wr_ready   = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cmd_d   = cmd;
               rem_d   = len;
               wr_d    = wr;
               word0_d = 1'b1;
               cnt_d   = 8'd0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            io_enable = 1'b1;
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_STROBE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_STROBE: begin
            io_enable = 1'b1;
            io_strobe = 1'b1;
            if (word0_q) begin
               io_din = cmd_q;
            end else begin
               rem_d = rem_q - 5'd1;
               if (wr_q) begin
                  io_din   = wr_data;
                  wr_ready = 1'b1;
               end
            end
            cnt_d   = 8'd0;
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            io_enable = 1'b1;
            if (cnt_q == 8'd0) begin
               if (word0_q) begin
                  status_d = io_dout;
                  err_d    = ~dout_en;
               end else if (!wr_q) begin
                  rd_data_d  = io_dout;
                  rd_valid_d = 1'b1;
               end
            end
`ifdef HPS_EXTM_ABORT_EN
            // With GAP=1 err_q is not yet updated, so use the live dout_en.
            abort = word0_q && ((cnt_q == 8'd0) ? !dout_en : err_q);
`endif
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 8'd0;
               word0_d = 1'b0;
               if (rem_q == 5'd0 || abort) state_d = S_DISABLE;
               else if (wr_q)              state_d = S_WAITW;
               else                        state_d = S_STROBE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WAITW: begin
            io_enable = 1'b1;
            if (wr_valid) state_d = S_STROBE;
         end
         S_DISABLE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         rem_q      <= 5'd0;
         word0_q    <= 1'b0;
         cmd_q      <= 16'h0000;
         wr_q       <= 1'b0;
         status_q   <= 16'h0000;
         err_q      <= 1'b0;
         rd_data_q  <= 16'h0000;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         word0_q    <= word0_d;
         cmd_q      <= cmd_d;
         wr_q       <= wr_d;
         status_q   <= status_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign status    = status_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule
